// File: rtl/control_cmd_rect_ex.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// control_cmd_rect_ex
//
// Rectangle command engine. Captures a streamed header (mode, x, y, width,
// height, color), clips the rectangle to the panel, then emits one
// frame-buffer byte write per clock. Supports fill and outline modes,
// multi-byte big-endian coordinates and empty-rectangle short-circuit.
//
// Ports:
//   clk              single clock
//   reset            asynchronous, active-low reset
//   enable           header byte valid (accepted when ready_for_data=1)
//   data_in          header byte stream
//   row / column     registered write address
//   pixel            registered byte lane within the pixel
//   data_out         registered write data
//   ram_write_enable one byte written per asserted cycle
//   ram_access_start pulse on the first write cycle of a command
//   ready_for_data   header byte acceptance (all capture states)
//   done             one-cycle completion pulse
// -----------------------------------------------------------------------------

package calc;
    function automatic int num_row_address_bits(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int num_column_address_bits(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
        return (bytes_per_pixel > 1) ? $clog2(bytes_per_pixel) : 1;
    endfunction
endpackage

module control_cmd_rect_ex #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int PIXEL_WIDTH     = 64,
    parameter int PIXEL_HEIGHT    = 32,
    parameter int COORD_BYTES     = 1
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  enable,
    input  logic [7:0]                                            data_in,
    output logic [calc::num_row_address_bits(PIXEL_HEIGHT)-1:0]   row,
    output logic [calc::num_column_address_bits(PIXEL_WIDTH)-1:0] column,
    output logic [calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL)-1:0] pixel,
    output logic [7:0]                                            data_out,
    output logic                                                  ram_write_enable,
    output logic                                                  ram_access_start,
    output logic                                                  ready_for_data,
    output logic                                                  done
);

    localparam int RB = calc::num_row_address_bits(PIXEL_HEIGHT);
    localparam int CB = calc::num_column_address_bits(PIXEL_WIDTH);
    localparam int PB = calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL);
    localparam int CW = COORD_BYTES * 8;
    localparam int KW = BYTES_PER_PIXEL * 8;

    // Panel bounds at the widened clip width so x+w never overflows.
    localparam logic [CW:0]   PW_L      = (CW+1)'(PIXEL_WIDTH);
    localparam logic [CW:0]   PH_L      = (CW+1)'(PIXEL_HEIGHT);
    localparam logic [PB-1:0] LANE_TOP  = PB'(BYTES_PER_PIXEL - 1);

    typedef enum logic [3:0] {
        IDLE, CAP_MODE, CAP_X, CAP_Y, CAP_W, CAP_H, CAP_COLOR, CLIP, WRITE, DONE
    } state_t;

    state_t          r_state, w_next_state;

    // Header capture
    logic [2:0]      r_byte_cnt;
    logic [2:0]      w_field_len;
    logic            w_accept, w_last_byte, w_capturing;
    logic            r_outline;
    logic [CW-1:0]   r_x, r_y, r_w, r_h;
    logic [KW-1:0]   r_color;

    // Clip results (combinational from the captured header)
    logic [CW:0]     w_x_end, w_y_end, w_x_lim, w_y_lim;
    logic            w_right_ok, w_bottom_ok, w_empty;
    logic [CB-1:0]   w_x2;
    logic [RB-1:0]   w_y2;

    // Clipped geometry held for the write walk
    logic [CB-1:0]   r_x_left, r_x2;
    logic [RB-1:0]   r_y_top, r_y2;
    logic            r_right_ok, r_bottom_ok;

    // Write walk
    logic [RB-1:0]   r_row, w_next_row;
    logic [CB-1:0]   r_col, w_next_col;
    logic [PB-1:0]   r_lane, w_next_lane;
    logic [7:0]      r_data;
    logic            w_full_row, w_has_right, w_row_end, w_pixel_end, w_last_write;

    // Registered strobes
    logic            r_we, r_start, r_ready, r_done;

    // Lane 0 carries the most significant color byte.
    function automatic logic [7:0] lane_byte(input logic [KW-1:0] color,
                                             input logic [PB-1:0] lane);
        logic [KW-1:0] shifted;
        shifted = color >> (8 * (BYTES_PER_PIXEL - 1 - int'(lane)));
        return shifted[7:0];
    endfunction

    assign w_capturing = (r_state inside {CAP_MODE, CAP_X, CAP_Y, CAP_W, CAP_H, CAP_COLOR});
    assign w_accept    = enable && r_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        w_field_len = 3'(COORD_BYTES);
        if (r_state == CAP_MODE)
            w_field_len = 3'd1;
        else if (r_state == CAP_COLOR)
            w_field_len = 3'(BYTES_PER_PIXEL);
    end

    assign w_last_byte = (r_byte_cnt == (w_field_len - 3'd1));

    // Clipping arithmetic at CW+1 bits.
    assign w_x_end     = {1'b0, r_x} + {1'b0, r_w};
    assign w_y_end     = {1'b0, r_y} + {1'b0, r_h};
    assign w_right_ok  = (w_x_end <= PW_L);
    assign w_bottom_ok = (w_y_end <= PH_L);
    assign w_x_lim     = w_right_ok  ? w_x_end : PW_L;
    assign w_y_lim     = w_bottom_ok ? w_y_end : PH_L;
    assign w_x2        = CB'(w_x_lim - 1'b1);
    assign w_y2        = RB'(w_y_lim - 1'b1);
    assign w_empty     = (r_w == '0) || (r_h == '0) ||
                         ({1'b0, r_x} >= PW_L) || ({1'b0, r_y} >= PH_L);

    // Write walk. Full rows visit every column; outline interior rows visit
    // only the left column and, if the right edge survived, jump straight
    // to the right column.
    assign w_full_row   = !r_outline || (r_row == r_y_top) || (r_bottom_ok && (r_row == r_y2));
    assign w_has_right  = r_right_ok && (r_x2 != r_x_left);
    assign w_row_end    = w_full_row ? (r_col == r_x2) : !((r_col == r_x_left) && w_has_right);
    assign w_pixel_end  = (r_lane == '0);
    assign w_last_write = w_pixel_end && w_row_end && (r_row == r_y2);

    always_comb begin
        w_next_row  = r_row;
        w_next_col  = r_col;
        w_next_lane = r_lane;
        if (!w_pixel_end) begin
            w_next_lane = r_lane - 1'b1;
        end else begin
            w_next_lane = LANE_TOP;
            if (!w_row_end) begin
                w_next_col = w_full_row ? (r_col + 1'b1) : r_x2;
            end else begin
                w_next_row = r_row + 1'b1;
                w_next_col = r_x_left;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      w_next_state = CAP_MODE;
            CAP_MODE:  if (w_accept && w_last_byte) w_next_state = CAP_X;
            CAP_X:     if (w_accept && w_last_byte) w_next_state = CAP_Y;
            CAP_Y:     if (w_accept && w_last_byte) w_next_state = CAP_W;
            CAP_W:     if (w_accept && w_last_byte) w_next_state = CAP_H;
            CAP_H:     if (w_accept && w_last_byte) w_next_state = CAP_COLOR;
            CAP_COLOR: if (w_accept && w_last_byte) w_next_state = CLIP;
            CLIP:      w_next_state = w_empty ? DONE : WRITE;
            WRITE:     if (w_last_write) w_next_state = DONE;
            DONE:      w_next_state = CAP_MODE;
            default:   w_next_state = IDLE;
        endcase
    end

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_byte_cnt  <= '0;
            r_outline   <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_color     <= '0;
            r_x_left    <= '0;
            r_x2        <= '0;
            r_y_top     <= '0;
            r_y2        <= '0;
            r_right_ok  <= 1'b0;
            r_bottom_ok <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_lane      <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_start     <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Header fields shift in MSB first; exactly field-length bytes
            // are shifted, so earlier contents fall off the top.
            if (w_capturing && w_accept) begin
                r_byte_cnt <= w_last_byte ? 3'd0 : (r_byte_cnt + 3'd1);
                case (r_state)
                    CAP_MODE:  r_outline <= data_in[0];
                    CAP_X:     r_x       <= CW'({r_x, data_in});
                    CAP_Y:     r_y       <= CW'({r_y, data_in});
                    CAP_W:     r_w       <= CW'({r_w, data_in});
                    CAP_H:     r_h       <= CW'({r_h, data_in});
                    CAP_COLOR: r_color   <= KW'({r_color, data_in});
                    default:   ;
                endcase
            end

            if (r_state == CLIP) begin
                r_x_left    <= CB'(r_x);
                r_y_top     <= RB'(r_y);
                r_x2        <= w_x2;
                r_y2        <= w_y2;
                r_right_ok  <= w_right_ok;
                r_bottom_ok <= w_bottom_ok;
                r_row       <= RB'(r_y);
                r_col       <= CB'(r_x);
                r_lane      <= LANE_TOP;
                r_data      <= lane_byte(r_color, LANE_TOP);
            end else if ((r_state == WRITE) && !w_last_write) begin
                r_row  <= w_next_row;
                r_col  <= w_next_col;
                r_lane <= w_next_lane;
                r_data <= lane_byte(r_color, w_next_lane);
            end

            // Strobes are registered from the next state so they line up
            // with the state they describe.
            r_we    <= (w_next_state == WRITE);
            r_start <= (r_state == CLIP) && (w_next_state == WRITE);
            r_done  <= (w_next_state == DONE);
            r_ready <= (w_next_state inside {CAP_MODE, CAP_X, CAP_Y, CAP_W, CAP_H, CAP_COLOR});
        end
    end

    assign row              = r_row;
    assign column           = r_col;
    assign pixel            = r_lane;
    assign data_out         = r_data;
    assign ram_write_enable = r_we;
    assign ram_access_start = r_start;
    assign ready_for_data   = r_ready;
    assign done             = r_done;

endmodule

// File: tb/tb_control_cmd_rect_ex.sv
`timescale 1ns/1ps
// Testbench for control_cmd_rect_ex: 8x8 panel, two bytes per pixel,
// two-byte coordinates. A driver streams headers and queues the expected
// writes from a pixel-set reference model; a monitor compares every write
// and every done pulse against those queues.
module tb_control_cmd_rect_ex;

    localparam int BPP = 2;
    localparam int PW  = 8;
    localparam int PH  = 8;
    localparam int CBY = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [calc::num_row_address_bits(PH)-1:0]      row;
    logic [calc::num_column_address_bits(PW)-1:0]   column;
    logic [calc::num_pixelcolorselect_bits(BPP)-1:0] pixel;
    logic [7:0] data_out;
    logic ram_write_enable, ram_access_start, ready_for_data, done;

    control_cmd_rect_ex #(
        .BYTES_PER_PIXEL(BPP),
        .PIXEL_WIDTH    (PW),
        .PIXEL_HEIGHT   (PH),
        .COORD_BYTES    (CBY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .data_in         (data_in),
        .row             (row),
        .column          (column),
        .pixel           (pixel),
        .data_out        (data_out),
        .ram_write_enable(ram_write_enable),
        .ram_access_start(ram_access_start),
        .ready_for_data  (ready_for_data),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int lane;
        int data;
        int first;
    } wr_t;

    typedef struct {
        int nwr;
        int acc;
    } cmd_t;

    wr_t  exp_q[$];
    cmd_t cmd_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_acc = 0;
    int wr_cnt = 0;
    int st_cnt = 0;
    int last_wr_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    // Reference model: the set of pixels a command covers, in raster order,
    // each expanded into its byte lanes (lane 0 = color MSB).
    function automatic int model_cmd(input int outline, input int x, input int y,
                                     input int w, input int h, input int color);
        int xe, ye, n;
        bit right_ok, bottom_ok, on_edge;
        wr_t e;
        xe = (x + w < PW) ? x + w : PW;
        ye = (y + h < PH) ? y + h : PH;
        right_ok  = (x + w <= PW);
        bottom_ok = (y + h <= PH);
        n = 0;
        for (int r = y; r < ye; r++) begin
            for (int c = x; c < xe; c++) begin
                on_edge = (r == y) || (bottom_ok && r == y + h - 1) ||
                          (c == x) || (right_ok && c == x + w - 1);
                if (outline == 0 || on_edge) begin
                    for (int lane = BPP - 1; lane >= 0; lane--) begin
                        e.r     = r;
                        e.c     = c;
                        e.lane  = lane;
                        e.data  = (color >> (8 * (BPP - 1 - lane))) & 8'hFF;
                        e.first = (n == 0) ? 1 : 0;
                        exp_q.push_back(e);
                        n++;
                    end
                end
            end
        end
        return n;
    endfunction

    // Monitor: compares each write and each done pulse with the queues.
    always @(negedge clk) begin
        wr_t  e;
        cmd_t c;
        if (!reset) begin
            wr_cnt <= 0;
            st_cnt <= 0;
        end else begin
            if (ram_write_enable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_row",   int'(row),      e.r);
                    check("wr_col",   int'(column),   e.c);
                    check("wr_lane",  int'(pixel),    e.lane);
                    check("wr_data",  int'(data_out), e.data);
                    check("wr_start", int'(ram_access_start), e.first);
                    if (e.first != 0) begin
                        if (cmd_q.size() == 0) check("write_before_header_end", 1, 0);
                        else check("first_write_latency", cyc - cmd_q[0].acc, 1);
                    end else begin
                        check("write_contiguous", cyc - last_wr_cyc, 1);
                    end
                end
                wr_cnt      <= wr_cnt + 1;
                st_cnt      <= st_cnt + int'(ram_access_start);
                last_wr_cyc <= cyc;
            end else if (ram_access_start) begin
                check("start_without_write", 1, 0);
            end

            if (done) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    c = cmd_q.pop_front();
                    check("done_write_count", wr_cnt, c.nwr);
                    check("done_start_count", st_cnt, int'(c.nwr > 0));
                    check("done_we_low", int'(ram_write_enable), 0);
                    if (c.nwr > 0) check("done_after_last_write", cyc - last_wr_cyc, 1);
                    else           check("empty_done_latency", cyc - c.acc, 1);
                end
                wr_cnt <= 0;
                st_cnt <= 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        @(negedge clk);
        n = 0;
        while (!ready_for_data && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_for_data) check("ready_wait", 0, 1);
        enable  = 1'b1;
        data_in = b;
        @(posedge clk);
        #1;
        last_acc = cyc;
        enable   = 1'b0;
        data_in  = 8'($urandom);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("ready_in_gap", int'(ready_for_data), 1);
        end
    endtask

    task automatic send_header(input int outline, input int x, input int y,
                               input int w, input int h, input int color, input int gap);
        int nwr;
        logic [7:0]  mb;
        logic [15:0] xv, yv, wv, hv, cv;
        cmd_t c;
        nwr = model_cmd(outline, x, y, w, h, color);
        mb = 8'($urandom);
        mb[0] = outline[0];
        xv = 16'(x);
        yv = 16'(y);
        wv = 16'(w);
        hv = 16'(h);
        cv = 16'(color);
        send_byte(mb, gap);
        send_byte(xv[15:8], gap);
        send_byte(xv[7:0],  gap);
        send_byte(yv[15:8], gap);
        send_byte(yv[7:0],  gap);
        send_byte(wv[15:8], gap);
        send_byte(wv[7:0],  gap);
        send_byte(hv[15:8], gap);
        send_byte(hv[7:0],  gap);
        send_byte(cv[15:8], gap);
        send_byte(cv[7:0],  0);
        c.nwr = nwr;
        c.acc = last_acc;
        cmd_q.push_back(c);
    endtask

    // Waits for done while throwing junk at enable/data_in, which the DUT
    // must ignore outside the capture states.
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (done) begin
                seen   = 1'b1;
                enable = 1'b0;
                break;
            end
            enable  = 1'($urandom);
            data_in = 8'($urandom);
        end
        enable = 1'b0;
        check("done_seen", int'(seen), 1);
        if (seen) begin
            @(negedge clk);
            check("ready_after_done", int'(ready_for_data), 1);
        end
    endtask

    task automatic run_cmd(input int outline, input int x, input int y,
                           input int w, input int h, input int color, input int gap);
        send_header(outline, x, y, w, h, color, gap);
        wait_done();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_row"},   int'(row),              0);
        check({tag, "_col"},   int'(column),           0);
        check({tag, "_pixel"}, int'(pixel),            0);
        check({tag, "_data"},  int'(data_out),         0);
        check({tag, "_we"},    int'(ram_write_enable), 0);
        check({tag, "_start"}, int'(ram_access_start), 0);
        check({tag, "_ready"}, int'(ready_for_data),   0);
        check({tag, "_done"},  int'(done),             0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int outline, x, y, w, h, color, gap;

        // Reset state
        reset = 1'b0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("idle_ready", int'(ready_for_data), 0);

        // Directed cases
        run_cmd(0, 1, 1, 2, 2, 16'hBEEF, 0);       // basic fill, 8 writes
        run_cmd(1, 2, 2, 4, 4, 16'h1234, 0);       // outline, 24 writes
        run_cmd(0, 6, 6, 5, 5, 16'hC3A5, 0);       // clipped fill
        run_cmd(1, 6, 6, 5, 5, 16'h5A5A, 1);       // clipped outline, no right/bottom edge
        run_cmd(0, 2, 2, 0, 3, 16'hFFFF, 0);       // empty: w=0
        run_cmd(1, 8, 1, 2, 2, 16'h0101, 0);       // empty: x off panel
        run_cmd(0, 16'h0001, 0, 16'h0003, 2, 16'h7E81, 3); // stalled capture
        run_cmd(0, 7, 0, 16'hFFFF, 1, 16'h0F0F, 0);  // x+w needs the extra bit
        run_cmd(0, 0, 16'h0100, 2, 2, 16'h2222, 0);  // upper coordinate byte -> empty
        run_cmd(1, 3, 1, 1, 5, 16'h9966, 0);       // one-column outline
        run_cmd(1, 0, 7, 8, 3, 16'hABCD, 0);       // single surviving row

        // Reset in the middle of a write run
        send_header(0, 1, 1, 2, 2, 16'h1234, 0);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (wr_cnt == 3) break;
        end
        check("reached_third_write", wr_cnt, 3);
        reset = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        exp_q.delete();
        cmd_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("no_write_in_reset", int'(ram_write_enable), 0);
        end
        #2 reset = 1'b1;
        #1 check("post_reset_idle_ready", int'(ready_for_data), 0);
        run_cmd(0, 2, 3, 3, 2, 16'hA55A, 1);

        // Randomized commands
        for (int i = 0; i < 30; i++) begin
            outline = int'($urandom_range(0, 1));
            x       = int'($urandom_range(0, 9));
            y       = int'($urandom_range(0, 9));
            w       = int'($urandom_range(0, 6));
            h       = int'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) w = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) h = int'($urandom_range(0, 65535));
            color   = int'($urandom_range(0, 65535));
            gap     = int'($urandom_range(0, 2));
            run_cmd(outline, x, y, w, h, color, gap);
        end

        repeat (3) @(negedge clk);
        check("writes_left_over", exp_q.size(), 0);
        check("commands_left_over", cmd_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
